// File: rtl/nbody_pkg.sv
// rtl/nbody_pkg.sv - shared types and constants for the n-body acceleration sequencer
//
// Purpose: word width, body capacity, default pipeline timing, FSM state type
//          and the delay-line entry layout used by the sequencer and its delay line.
// Ports:   none (package).
package nbody_pkg;

  localparam int FP_W         = 32;
  localparam int N_MAX        = 64;
  localparam int AW           = $clog2(N_MAX);
  localparam int DEF_LATENCY  = 24;
  localparam int DEF_A_OFFSET = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_SRC = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DUMP     = 3'd4
  } state_t;

  // One entry per issued slot; travels alongside the pipeline operands.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] idx;
    logic          first;
  } dl_entry_t;

endpackage

// File: rtl/nbody_delay_line.sv
// rtl/nbody_delay_line.sv - slot-tracking shift register with two taps
//
// Purpose: follows each issued slot through the external pipeline so the
//          sequencer knows which body a tap cycle belongs to.
// Ports:   i_clk, i_rst (async, active-low)
//          i_entry  - entry registered in the same cycle as the operands
//          o_tap_a  - entry DEPTH_A cycles after issue (previous-acc read point)
//          o_tap_l  - entry DEPTH cycles after issue (result write point)
module nbody_delay_line
  import nbody_pkg::*;
#(
  parameter int DEPTH   = DEF_LATENCY,
  parameter int DEPTH_A = DEF_A_OFFSET
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  dl_entry_t i_entry,
  output dl_entry_t o_tap_a,
  output dl_entry_t o_tap_l
);

  // stage_q[0] is aligned with the registered operands, stage_q[d] is d cycles later.
  dl_entry_t stage_q [DEPTH+1];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i <= DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= i_entry;
      for (int i = 1; i <= DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign o_tap_a = stage_q[DEPTH_A];
  assign o_tap_l = stage_q[DEPTH];

endmodule

// File: rtl/nbody_accel_sequencer.sv
// rtl/nbody_accel_sequencer.sv - drives the pairwise acceleration pipeline and streams results
//
// Purpose: for each source body j sweeps all targets, feeds operands plus the
//          target's running acceleration to the pipeline, accumulates results
//          per body, then streams final accelerations with valid/ready.
// Ports:   i_clk, i_rst (async, active-low); i_start, i_n_bodies; o_busy, o_done, o_err
//          o_tgt_addr, o_src_addr / i_tgt_*, i_src_* : body RAM (1-cycle read)
//          o_acc_b1_*, o_acc_b2_*, o_acc_m_b2, o_acc_a_* / i_res_* : pipeline
//          o_res_valid, i_res_ready, o_res_idx, o_res_ax, o_res_ay : result stream
//          o_perf_cycles : busy-cycle counter, present only with NBODY_SEQ_PERF_CNT_EN
module nbody_accel_sequencer
  import nbody_pkg::*;
#(
  parameter int LATENCY  = DEF_LATENCY,
  parameter int A_OFFSET = DEF_A_OFFSET
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [AW:0]     i_n_bodies,
`ifdef NBODY_SEQ_PERF_CNT_EN
  output logic [31:0]     o_perf_cycles,
`endif
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [AW-1:0]   o_tgt_addr,
  output logic [AW-1:0]   o_src_addr,
  input  logic [FP_W-1:0] i_tgt_x,
  input  logic [FP_W-1:0] i_tgt_y,
  input  logic [FP_W-1:0] i_src_x,
  input  logic [FP_W-1:0] i_src_y,
  input  logic [FP_W-1:0] i_src_m,
  output logic [FP_W-1:0] o_acc_b1_x,
  output logic [FP_W-1:0] o_acc_b1_y,
  output logic [FP_W-1:0] o_acc_b2_x,
  output logic [FP_W-1:0] o_acc_b2_y,
  output logic [FP_W-1:0] o_acc_m_b2,
  output logic [FP_W-1:0] o_acc_a_x,
  output logic [FP_W-1:0] o_acc_a_y,
  input  logic [FP_W-1:0] i_res_x,
  input  logic [FP_W-1:0] i_res_y,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic [AW-1:0]   o_res_idx,
  output logic [FP_W-1:0] o_res_ax,
  output logic [FP_W-1:0] o_res_ay
);

  localparam int          CW       = $clog2(LATENCY + 1);
  // Minimum sweep length keeps round j's write ahead of round j+1's read.
  localparam logic [AW:0] MIN_S    = (AW+1)'(LATENCY - A_OFFSET + 1);
  localparam logic [AW:0] N_MAX_W  = (AW+1)'(N_MAX);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [AW:0]   n_q, n_d, k_q, k_d;
  logic [AW-1:0] j_q, j_d, tgt_q, tgt_d, src_q, src_d, res_idx_q, res_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d, res_valid_q, res_valid_d;
  logic [FP_W-1:0] b1x_q, b1y_q, b2x_q, b2y_q, m_q;
  logic [FP_W-1:0] acc_x_q [N_MAX];
  logic [FP_W-1:0] acc_y_q [N_MAX];

  logic        n_ok, last_k, last_j, slot_valid;
  logic [AW:0] s_len;
  dl_entry_t   issue_entry, tap_a, tap_l;

  assign n_ok   = (i_n_bodies >= (AW+1)'(2)) && (i_n_bodies <= N_MAX_W);
  assign s_len  = (n_q > MIN_S) ? n_q : MIN_S;
  assign last_k = (k_q == s_len - 1'b1);
  assign last_j = ({1'b0, j_q} == n_q - 1'b1);
  assign slot_valid = (state_q == ST_ISSUE) && (k_q < n_q) && (k_q[AW-1:0] != j_q);

  // Body 0 is skipped in round 0, so its first contribution arrives in round 1;
  // marking that slot "first" lets the accumulator start from +0.0 without a clear.
  always_comb begin
    issue_entry       = '0;
    issue_entry.valid = slot_valid;
    issue_entry.idx   = k_q[AW-1:0];
    issue_entry.first = (j_q == '0) || ((j_q == AW'(1)) && (k_q == '0));
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    j_d         = j_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    src_d       = src_q;
    res_idx_d   = res_idx_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (n_ok) begin
            state_d = ST_LOAD_SRC;
            n_d     = i_n_bodies;
            j_d     = '0;
            src_d   = '0;
            tgt_d   = '0;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD_SRC: begin
        state_d = ST_ISSUE;
        k_d     = '0;
        tgt_d   = AW'(1);
      end
      ST_ISSUE: begin
        if (last_k) begin
          if (last_j) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            state_d = ST_LOAD_SRC;
            j_d     = j_q + 1'b1;
            src_d   = j_q + 1'b1;
            tgt_d   = '0;
          end
        end else begin
          k_d   = k_q + 1'b1;
          tgt_d = AW'(k_q + (AW+1)'(2));
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d     = ST_DUMP;
          res_idx_d   = '0;
          res_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DUMP: begin
        if (i_res_ready) begin
          if ({1'b0, res_idx_q} == n_q - 1'b1) begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            res_idx_d = res_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      tgt_q       <= '0;
      src_q       <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      j_q         <= j_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      src_q       <= src_d;
      res_idx_q   <= res_idx_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Invalid slots present zero operands so the pipeline sees clean inputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      b1x_q <= '0; b1y_q <= '0; b2x_q <= '0; b2y_q <= '0; m_q <= '0;
    end else if (slot_valid) begin
      b1x_q <= i_tgt_x; b1y_q <= i_tgt_y; b2x_q <= i_src_x; b2y_q <= i_src_y; m_q <= i_src_m;
    end else begin
      b1x_q <= '0; b1y_q <= '0; b2x_q <= '0; b2y_q <= '0; m_q <= '0;
    end
  end

  nbody_delay_line #(.DEPTH(LATENCY), .DEPTH_A(A_OFFSET)) u_dl (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_entry (issue_entry),
    .o_tap_a (tap_a),
    .o_tap_l (tap_l)
  );

  always_ff @(posedge i_clk) begin
    if (tap_l.valid) begin
      acc_x_q[tap_l.idx] <= i_res_x;
      acc_y_q[tap_l.idx] <= i_res_y;
    end
  end

  assign o_acc_a_x = (tap_a.valid && !tap_a.first) ? acc_x_q[tap_a.idx] : '0;
  assign o_acc_a_y = (tap_a.valid && !tap_a.first) ? acc_y_q[tap_a.idx] : '0;

`ifdef NBODY_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                    perf_q <= '0;
    else if (state_q == ST_IDLE && i_start && n_ok) perf_q <= '0;
    else if (busy_q)                               perf_q <= perf_q + 32'd1;
  end
  assign o_perf_cycles = perf_q;
`endif

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_tgt_addr  = tgt_q;
  assign o_src_addr  = src_q;
  assign o_acc_b1_x  = b1x_q;
  assign o_acc_b1_y  = b1y_q;
  assign o_acc_b2_x  = b2x_q;
  assign o_acc_b2_y  = b2y_q;
  assign o_acc_m_b2  = m_q;
  assign o_res_valid = res_valid_q;
  assign o_res_idx   = res_idx_q;
  assign o_res_ax    = res_valid_q ? acc_x_q[res_idx_q] : '0;
  assign o_res_ay    = res_valid_q ? acc_y_q[res_idx_q] : '0;

endmodule

// File: tb/tb_nbody_accel_sequencer.sv
// tb/tb_nbody_accel_sequencer.sv - scoreboard bench for nbody_accel_sequencer with a +1.0 pipeline stub
module tb_nbody_accel_sequencer;

  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic [AW:0] i_n_bodies = '0;
  logic i_res_ready = 1'b1;
  logic o_busy, o_done, o_err, o_res_valid;
  logic [AW-1:0] o_tgt_addr, o_src_addr, o_res_idx;
  logic [31:0] tgt_x, tgt_y, src_x, src_y, src_m;
  logic [31:0] o_acc_b1_x, o_acc_b1_y, o_acc_b2_x, o_acc_b2_y, o_acc_m_b2, o_acc_a_x, o_acc_a_y;
  logic [31:0] res_x, res_y, o_res_ax, o_res_ay;
`ifdef NBODY_SEQ_PERF_CNT_EN
  logic [31:0] o_perf_cycles;
`endif

  always #5 clk = ~clk;

  nbody_accel_sequencer dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(i_start), .i_n_bodies(i_n_bodies),
`ifdef NBODY_SEQ_PERF_CNT_EN
    .o_perf_cycles(o_perf_cycles),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_tgt_addr(o_tgt_addr), .o_src_addr(o_src_addr),
    .i_tgt_x(tgt_x), .i_tgt_y(tgt_y), .i_src_x(src_x), .i_src_y(src_y), .i_src_m(src_m),
    .o_acc_b1_x(o_acc_b1_x), .o_acc_b1_y(o_acc_b1_y), .o_acc_b2_x(o_acc_b2_x),
    .o_acc_b2_y(o_acc_b2_y), .o_acc_m_b2(o_acc_m_b2), .o_acc_a_x(o_acc_a_x), .o_acc_a_y(o_acc_a_y),
    .i_res_x(res_x), .i_res_y(res_y),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_idx(o_res_idx),
    .o_res_ax(o_res_ax), .o_res_ay(o_res_ay)
  );

  // Small non-negative integers to/from IEEE-754 single.
  function automatic logic [31:0] f_enc(input int v);
    int e;
    logic [31:0] m;
    if (v <= 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 16; b++) if (v >= (1 << b)) e = b;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int f_dec(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return -1;
    m = {9'd0, f[22:0]} >> (23 - e);
    return (1 << e) + int'(m);
  endfunction

  // Body RAM: x = i+1, y = i+65, m = i+129, one-cycle read latency.
  always @(posedge clk) begin
    tgt_x <= f_enc(int'(o_tgt_addr) + 1);
    tgt_y <= f_enc(int'(o_tgt_addr) + 65);
    src_x <= f_enc(int'(o_src_addr) + 1);
    src_y <= f_enc(int'(o_src_addr) + 65);
    src_m <= f_enc(int'(o_src_addr) + 129);
  end

  // Pipeline stub: samples a_prev A_OFFSET cycles after issue, returns a_prev + 1.0 at LATENCY.
  logic [31:0] px [4];
  logic [31:0] py [4];
  always @(posedge clk) begin
    px[0] <= o_acc_a_x;
    py[0] <= o_acc_a_y;
    for (int i = 1; i < 4; i++) begin
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  assign res_x = f_enc(f_dec(px[3]) + 1);
  assign res_y = f_enc(f_dec(py[3]) + 1);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { int idx; logic [31:0] ax; logic [31:0] ay; } exp_t;
  exp_t exp_q [$];

  int done_cnt = 0, err_cnt = 0, busy_cnt = 0, op_cnt = 0, op_bad = 0, coll_cnt = 0;
  int mon_t, mon_s;
  exp_t mon_e;

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
    if (o_busy) busy_cnt++;
    if (o_acc_m_b2 != 32'd0) begin
      op_cnt++;
      mon_t = f_dec(o_acc_b1_x) - 1;
      mon_s = f_dec(o_acc_b2_x) - 1;
      if (mon_t < 0 || mon_s < 0 || mon_t == mon_s || o_acc_b1_y != f_enc(mon_t + 65) ||
          o_acc_b2_y != f_enc(mon_s + 65) || o_acc_m_b2 != f_enc(mon_s + 129)) op_bad++;
    end else if ((o_acc_b1_x | o_acc_b1_y | o_acc_b2_x | o_acc_b2_y) != 32'd0) begin
      op_bad++;
    end
    if (dut.tap_l.valid && dut.tap_a.valid && !dut.tap_a.first && dut.tap_l.idx == dut.tap_a.idx)
      coll_cnt++;
    if (o_res_valid && i_res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(o_res_idx), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_idx", 32'(o_res_idx), 32'(mon_e.idx));
        check("res_ax", o_res_ax, mon_e.ax);
        check("res_ay", o_res_ay, mon_e.ay);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic run_case(input int n, input int val, input bit stall);
    int cyc, s, d0, b0, o0, ob0, c0;
    bit seen;
    s = (n > 5) ? n : 5;
    for (int i = 0; i < n; i++) exp_q.push_back('{i, f_enc(val), f_enc(val)});
    d0 = done_cnt; b0 = busy_cnt; o0 = op_cnt; ob0 = op_bad; c0 = coll_cnt;
    i_n_bodies = (AW+1)'(n);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    cyc = 0;
    while (!o_res_valid && cyc < 20000) begin
      tick;
      cyc++;
    end
    check("first_valid_latency", 32'(cyc), 32'(n * (1 + s) + 24));
    if (stall) begin
      cyc = 0;
      while (!(o_res_valid && o_res_idx == AW'(2)) && cyc < 200) begin
        tick;
        cyc++;
      end
      i_res_ready = 1'b0;
      for (int t = 0; t < 5; t++) begin
        tick;
        check("stall_valid", 32'(o_res_valid), 32'd1);
        check("stall_idx", 32'(o_res_idx), 32'd2);
        check("stall_ax", o_res_ax, f_enc(val));
      end
      i_res_ready = 1'b1;
    end
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 20000) begin
      tick;
      cyc++;
      if (o_done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    repeat (3) tick;
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("busy_after_done", 32'(o_busy), 32'd0);
    check("operand_slots", 32'(op_cnt - o0), 32'(n * (n - 1)));
    check("operand_errors", 32'(op_bad - ob0), 32'd0);
    check("acc_rw_collision", 32'(coll_cnt - c0), 32'd0);
    if (n == 4 && !stall) check("busy_cycles", 32'(busy_cnt - b0), 32'd52);
`ifdef NBODY_SEQ_PERF_CNT_EN
    check("perf_eq_busy", o_perf_cycles, 32'(busy_cnt - b0));
    if (n == 4 && !stall) check("perf_52", o_perf_cycles, 32'd52);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, b0, cyc, d0;
    int bad_n [2];
    bad_n[0] = 1;
    bad_n[1] = 65;
    repeat (3) tick;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_res_valid", 32'(o_res_valid), 32'd0);
    check("rst_tgt_addr", 32'(o_tgt_addr), 32'd0);
    check("rst_src_addr", 32'(o_src_addr), 32'd0);
    check("rst_b1_x", o_acc_b1_x, 32'd0);
    check("rst_m_b2", o_acc_m_b2, 32'd0);
    check("rst_a_x", o_acc_a_x, 32'd0);
    check("rst_res_ax", o_res_ax, 32'd0);
`ifdef NBODY_SEQ_PERF_CNT_EN
    check("rst_perf", o_perf_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 2; i++) begin
      e0 = err_cnt;
      b0 = busy_cnt;
      i_n_bodies = (AW+1)'(bad_n[i]);
      i_start = 1'b1;
      tick;
      i_start = 1'b0;
      repeat (4) tick;
      check("reject_err_pulse", 32'(err_cnt - e0), 32'd1);
      check("reject_busy", 32'(busy_cnt - b0), 32'd0);
      check("reject_tgt_addr", 32'(o_tgt_addr), 32'd0);
      check("reject_src_addr", 32'(o_src_addr), 32'd0);
    end

    run_case(4, 3, 1'b0);
    run_case(64, 63, 1'b0);
    run_case(4, 3, 1'b1);

    d0 = done_cnt;
    i_n_bodies = (AW+1)'(4);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    cyc = 0;
    while (!(o_busy && o_src_addr == AW'(1)) && cyc < 500) begin
      tick;
      cyc++;
    end
    check("abort_reached_round1", 32'(o_src_addr), 32'd1);
    repeat (2) tick;
    rst_n = 1'b0;
    tick;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_res_valid", 32'(o_res_valid), 32'd0);
    tick;
    rst_n = 1'b1;
    repeat (2) tick;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_case(3, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
